// File: rtl/rs_pkg.sv
// Shared definitions for the reservation station: op codes, op width and ROB age helpers.
package rs_pkg;

  localparam int OP_W = 4;

  localparam logic [OP_W-1:0] OP_ADD = 4'd0;
  localparam logic [OP_W-1:0] OP_SUB = 4'd1;
  localparam logic [OP_W-1:0] OP_SLL = 4'd2;
  localparam logic [OP_W-1:0] OP_XOR = 4'd3;
  localparam logic [OP_W-1:0] OP_SRL = 4'd4;
  localparam logic [OP_W-1:0] OP_SRA = 4'd5;
  localparam logic [OP_W-1:0] OP_OR  = 4'd6;
  localparam logic [OP_W-1:0] OP_AND = 4'd7;
  localparam logic [OP_W-1:0] OP_EQ  = 4'd8;
  localparam logic [OP_W-1:0] OP_NE  = 4'd9;
  localparam logic [OP_W-1:0] OP_LT  = 4'd10;
  localparam logic [OP_W-1:0] OP_GE  = 4'd11;
  localparam logic [OP_W-1:0] OP_LTU = 4'd12;
  localparam logic [OP_W-1:0] OP_GEU = 4'd13;

  // Distance of a tag from the ROB head, modulo the ROB size.
  function automatic logic [31:0] rob_age(input logic [31:0] dest, input logic [31:0] head,
                                          input int unsigned width);
    logic [31:0] mask;
    mask = (width >= 32'd32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    return (dest - head) & mask;
  endfunction

  function automatic logic is_older(input logic [31:0] age_a, input logic [31:0] age_b);
    return age_a < age_b;
  endfunction

endpackage

// File: rtl/rs_alu.sv
// Combinational integer ALU used by the reservation station issue path.
module rs_alu
  import rs_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [OP_W-1:0]       i_op,
  input  logic [DATA_WIDTH-1:0] i_a,
  input  logic [DATA_WIDTH-1:0] i_b,
  output logic [DATA_WIDTH-1:0] o_result
);

  localparam int SH_W = $clog2(DATA_WIDTH);

  logic [SH_W-1:0] w_shamt;
  assign w_shamt = i_b[SH_W-1:0];

  always_comb begin
    o_result = '0;
    case (i_op)
      OP_ADD:  o_result = i_a + i_b;
      OP_SUB:  o_result = i_a - i_b;
      OP_SLL:  o_result = i_a << w_shamt;
      OP_XOR:  o_result = i_a ^ i_b;
      OP_SRL:  o_result = i_a >> w_shamt;
      OP_SRA:  o_result = DATA_WIDTH'($signed(i_a) >>> w_shamt);
      OP_OR:   o_result = i_a | i_b;
      OP_AND:  o_result = i_a & i_b;
      OP_EQ:   o_result = {{(DATA_WIDTH-1){1'b0}}, (i_a == i_b)};
      OP_NE:   o_result = {{(DATA_WIDTH-1){1'b0}}, (i_a != i_b)};
      OP_LT:   o_result = {{(DATA_WIDTH-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
      OP_GE:   o_result = {{(DATA_WIDTH-1){1'b0}}, ($signed(i_a) >= $signed(i_b))};
      OP_LTU:  o_result = {{(DATA_WIDTH-1){1'b0}}, (i_a < i_b)};
      OP_GEU:  o_result = {{(DATA_WIDTH-1){1'b0}}, (i_a >= i_b)};
      default: o_result = '0;
    endcase
  end

endmodule

// File: rtl/reservation_station_gen.sv
// Integer reservation station with operand wakeup, oldest-first issue and a 1-cycle ALU result.
// Optional issue/full/drop statistics counters are enabled with the RS_STAT_EN macro.
module reservation_station_gen
  import rs_pkg::*;
#(
  parameter int ROB_WIDTH  = 4,
  parameter int RS_DEPTH   = 16,
  parameter int NUM_FWD    = 2,
  parameter int DATA_WIDTH = 32
) (
  input  logic                            clockIn,
  input  logic                            resetIn,
  input  logic                            readyIn,
  input  logic                            flushIn,
  input  logic [ROB_WIDTH-1:0]            robHead,
  input  logic                            addFlag,
  input  logic [OP_W-1:0]                 addOp,
  input  logic [DATA_WIDTH-1:0]           addVj,
  input  logic [ROB_WIDTH-1:0]            addQj,
  input  logic                            addQjBusy,
  input  logic [DATA_WIDTH-1:0]           addVk,
  input  logic [ROB_WIDTH-1:0]            addQk,
  input  logic                            addQkBusy,
  input  logic [ROB_WIDTH-1:0]            addDest,
  output logic                            full,
  output logic [$clog2(RS_DEPTH+1)-1:0]   count,
  input  logic [NUM_FWD-1:0]              fwdFlag,
  input  logic [NUM_FWD*DATA_WIDTH-1:0]   fwdVal,
  input  logic [NUM_FWD*ROB_WIDTH-1:0]    fwdDest,
`ifdef RS_STAT_EN
  output logic [31:0]                     statIssue,
  output logic [31:0]                     statFull,
  output logic [31:0]                     statDrop,
`endif
  output logic                            outFlag,
  output logic [DATA_WIDTH-1:0]           outVal,
  output logic [ROB_WIDTH-1:0]            outDest
);

  localparam int IDX_W = $clog2(RS_DEPTH);
  localparam int CNT_W = $clog2(RS_DEPTH+1);
  localparam int NCH   = NUM_FWD + 1;

  logic [RS_DEPTH-1:0]   r_busy;
  logic [RS_DEPTH-1:0]   r_qjb;
  logic [RS_DEPTH-1:0]   r_qkb;
  logic [OP_W-1:0]       r_op   [RS_DEPTH];
  logic [DATA_WIDTH-1:0] r_vj   [RS_DEPTH];
  logic [DATA_WIDTH-1:0] r_vk   [RS_DEPTH];
  logic [ROB_WIDTH-1:0]  r_qj   [RS_DEPTH];
  logic [ROB_WIDTH-1:0]  r_qk   [RS_DEPTH];
  logic [ROB_WIDTH-1:0]  r_dest [RS_DEPTH];
  logic                  r_out_flag;
  logic [DATA_WIDTH-1:0] r_out_val;
  logic [ROB_WIDTH-1:0]  r_out_dest;

  logic                  w_ch_flag [NCH];
  logic [ROB_WIDTH-1:0]  w_ch_tag  [NCH];
  logic [DATA_WIDTH-1:0] w_ch_val  [NCH];
  logic [RS_DEPTH-1:0]   w_wj_hit;
  logic [RS_DEPTH-1:0]   w_wk_hit;
  logic [DATA_WIDTH-1:0] w_wj_val  [RS_DEPTH];
  logic [DATA_WIDTH-1:0] w_wk_val  [RS_DEPTH];
  logic [DATA_WIDTH-1:0] w_add_vj;
  logic [DATA_WIDTH-1:0] w_add_vk;
  logic                  w_add_qjb;
  logic                  w_add_qkb;
  logic                  w_any_ready;
  logic [IDX_W-1:0]      w_sel_idx;
  logic [IDX_W-1:0]      w_free_idx;
  logic [CNT_W-1:0]      w_count;
  logic                  w_full;
  logic                  w_dispatch;
  logic                  w_issue;
  logic [DATA_WIDTH-1:0] w_alu_res;

  // Channel 0 is the station's own result; lower channel index has higher wakeup priority.
  always_comb begin
    w_ch_flag[0] = r_out_flag;
    w_ch_tag[0]  = r_out_dest;
    w_ch_val[0]  = r_out_val;
    for (int c = 0; c < NUM_FWD; c++) begin
      w_ch_flag[c+1] = fwdFlag[c];
      w_ch_tag[c+1]  = fwdDest[c*ROB_WIDTH +: ROB_WIDTH];
      w_ch_val[c+1]  = fwdVal[c*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_comb begin
    w_add_vj  = addVj;
    w_add_qjb = addQjBusy;
    w_add_vk  = addVk;
    w_add_qkb = addQkBusy;
    for (int c = NCH - 1; c >= 0; c--) begin
      if (addQjBusy && w_ch_flag[c] && (w_ch_tag[c] == addQj)) begin
        w_add_vj  = w_ch_val[c];
        w_add_qjb = 1'b0;
      end else begin
        w_add_vj  = w_add_vj;
      end
      if (addQkBusy && w_ch_flag[c] && (w_ch_tag[c] == addQk)) begin
        w_add_vk  = w_ch_val[c];
        w_add_qkb = 1'b0;
      end else begin
        w_add_vk  = w_add_vk;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < RS_DEPTH; i++) begin
      w_wj_hit[i] = 1'b0;
      w_wk_hit[i] = 1'b0;
      w_wj_val[i] = r_vj[i];
      w_wk_val[i] = r_vk[i];
      for (int c = NCH - 1; c >= 0; c--) begin
        if (w_ch_flag[c] && (w_ch_tag[c] == r_qj[i])) begin
          w_wj_hit[i] = 1'b1;
          w_wj_val[i] = w_ch_val[c];
        end else begin
          w_wj_hit[i] = w_wj_hit[i];
        end
        if (w_ch_flag[c] && (w_ch_tag[c] == r_qk[i])) begin
          w_wk_hit[i] = 1'b1;
          w_wk_val[i] = w_ch_val[c];
        end else begin
          w_wk_hit[i] = w_wk_hit[i];
        end
      end
    end
  end

  // Oldest ready entry relative to the ROB head; strict compare keeps ties on the lowest index.
  always_comb begin : select_blk
    logic [31:0] v_age;
    logic [31:0] v_best;
    w_any_ready = 1'b0;
    w_sel_idx   = '0;
    v_best      = 32'hFFFF_FFFF;
    for (int i = 0; i < RS_DEPTH; i++) begin
      v_age = rob_age(32'(r_dest[i]), 32'(robHead), ROB_WIDTH);
      if (r_busy[i] && !r_qjb[i] && !r_qkb[i] && (!w_any_ready || is_older(v_age, v_best))) begin
        w_any_ready = 1'b1;
        w_sel_idx   = IDX_W'(i);
        v_best      = v_age;
      end else begin
        v_best      = v_best;
      end
    end
  end

  always_comb begin
    w_free_idx = '0;
    w_count    = '0;
    for (int i = RS_DEPTH - 1; i >= 0; i--) begin
      if (!r_busy[i]) begin
        w_free_idx = IDX_W'(i);
      end else begin
        w_free_idx = w_free_idx;
      end
      w_count = w_count + CNT_W'(r_busy[i]);
    end
  end

  assign w_full     = &r_busy;
  assign w_dispatch = addFlag && readyIn && !flushIn && !w_full;
  assign w_issue    = readyIn && !flushIn && w_any_ready;
  assign full       = w_full;
  assign count      = w_count;
  assign outFlag    = r_out_flag;
  assign outVal     = r_out_val;
  assign outDest    = r_out_dest;

  rs_alu #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
    .i_op     (r_op[w_sel_idx]),
    .i_a      (r_vj[w_sel_idx]),
    .i_b      (r_vk[w_sel_idx]),
    .o_result (w_alu_res)
  );

  // Issue frees a registered-ready slot, so dispatch (lowest free slot) never lands on it.
  always_ff @(posedge clockIn or posedge resetIn) begin
    if (resetIn) begin
      r_busy     <= '0;
      r_qjb      <= '0;
      r_qkb      <= '0;
      r_out_flag <= 1'b0;
      r_out_val  <= '0;
      r_out_dest <= '0;
      for (int i = 0; i < RS_DEPTH; i++) begin
        r_op[i]   <= '0;
        r_vj[i]   <= '0;
        r_vk[i]   <= '0;
        r_qj[i]   <= '0;
        r_qk[i]   <= '0;
        r_dest[i] <= '0;
      end
    end else if (flushIn) begin
      r_busy     <= '0;
      r_out_flag <= 1'b0;
    end else if (readyIn) begin
      for (int i = 0; i < RS_DEPTH; i++) begin
        if (r_busy[i] && r_qjb[i] && w_wj_hit[i]) begin
          r_vj[i]  <= w_wj_val[i];
          r_qjb[i] <= 1'b0;
        end
        if (r_busy[i] && r_qkb[i] && w_wk_hit[i]) begin
          r_vk[i]  <= w_wk_val[i];
          r_qkb[i] <= 1'b0;
        end
      end
      r_out_flag <= w_any_ready;
      if (w_issue) begin
        r_busy[w_sel_idx] <= 1'b0;
        r_out_val         <= w_alu_res;
        r_out_dest        <= r_dest[w_sel_idx];
      end
      if (w_dispatch) begin
        r_busy[w_free_idx] <= 1'b1;
        r_op[w_free_idx]   <= addOp;
        r_vj[w_free_idx]   <= w_add_vj;
        r_qj[w_free_idx]   <= addQj;
        r_qjb[w_free_idx]  <= w_add_qjb;
        r_vk[w_free_idx]   <= w_add_vk;
        r_qk[w_free_idx]   <= addQk;
        r_qkb[w_free_idx]  <= w_add_qkb;
        r_dest[w_free_idx] <= addDest;
      end
    end
  end

`ifdef RS_STAT_EN
  // Counters wrap naturally and are deliberately untouched by flush.
  always_ff @(posedge clockIn or posedge resetIn) begin
    if (resetIn) begin
      statIssue <= 32'd0;
      statFull  <= 32'd0;
      statDrop  <= 32'd0;
    end else begin
      if (w_issue) statIssue <= statIssue + 32'd1;
      if (readyIn && w_full) statFull <= statFull + 32'd1;
      if (addFlag && readyIn && !flushIn && w_full) statDrop <= statDrop + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_reservation_station_gen.sv
// Scoreboard bench for reservation_station_gen: stimulus pushes expected results, a monitor pops them.
module tb_reservation_station_gen;

  logic        clk = 1'b0;
  logic        resetIn, readyIn, flushIn;
  logic [3:0]  robHead;
  logic        addFlag;
  logic [3:0]  addOp;
  logic [31:0] addVj, addVk;
  logic [3:0]  addQj, addQk, addDest;
  logic        addQjBusy, addQkBusy;
  logic        full;
  logic [4:0]  count;
  logic [1:0]  fwdFlag;
  logic [63:0] fwdVal;
  logic [7:0]  fwdDest;
  logic        outFlag;
  logic [31:0] outVal;
  logic [3:0]  outDest;
`ifdef RS_STAT_EN
  logic [31:0] statIssue, statFull, statDrop;
`endif

  typedef struct packed {
    logic [31:0] val;
    logic [3:0]  dest;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;
  logic live_edge = 1'b0;

  reservation_station_gen #(.ROB_WIDTH(4), .RS_DEPTH(16), .NUM_FWD(2), .DATA_WIDTH(32)) dut (
    .clockIn(clk), .resetIn(resetIn), .readyIn(readyIn), .flushIn(flushIn), .robHead(robHead),
    .addFlag(addFlag), .addOp(addOp), .addVj(addVj), .addQj(addQj), .addQjBusy(addQjBusy),
    .addVk(addVk), .addQk(addQk), .addQkBusy(addQkBusy), .addDest(addDest),
    .full(full), .count(count), .fwdFlag(fwdFlag), .fwdVal(fwdVal), .fwdDest(fwdDest),
`ifdef RS_STAT_EN
    .statIssue(statIssue), .statFull(statFull), .statDrop(statDrop),
`endif
    .outFlag(outFlag), .outVal(outVal), .outDest(outDest)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  // Only an enabled, non-flush edge can produce a new result.
  always @(posedge clk) live_edge <= readyIn && !flushIn && !resetIn;

  always @(negedge clk) begin
    if (live_edge && outFlag) begin
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_result: actual val=%h dest=%0d, required no result", outVal, outDest);
      end else begin
        mon_e = sb_q.pop_front();
        chk("result_val", outVal, mon_e.val);
        chk("result_dest", 32'(outDest), 32'(mon_e.dest));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_res(input logic [31:0] val, input logic [3:0] dest);
    exp_t e;
    e.val  = val;
    e.dest = dest;
    sb_q.push_back(e);
  endtask

  task automatic dispatch(input logic [3:0] op, input logic [31:0] vj, input logic [3:0] qj,
                          input logic qjb, input logic [31:0] vk, input logic [3:0] qk,
                          input logic qkb, input logic [3:0] dest);
    addFlag = 1'b1; addOp = op; addVj = vj; addQj = qj; addQjBusy = qjb;
    addVk = vk; addQk = qk; addQkBusy = qkb; addDest = dest;
    tick();
    addFlag = 1'b0;
  endtask

  task automatic drain(input int limit);
    for (int n = 0; n < limit && sb_q.size() != 0; n++) tick();
    chk("drain_empty", 32'(sb_q.size()), 32'd0);
    sb_q.delete();
  endtask

  initial begin : stim
    logic [3:0]  v_op [12];
    logic [31:0] v_a  [12];
    logic [31:0] v_b  [12];
    logic [31:0] v_r  [12];
    v_op = '{4'd5, 4'd10, 4'd12, 4'd15, 4'd2, 4'd4, 4'd3, 4'd7, 4'd9, 4'd8, 4'd13, 4'd11};
    v_a  = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd5, 32'd1, 32'h8000_0000,
             32'h0000_F0F0, 32'h0000_F0F0, 32'd3, 32'd3, 32'd1, 32'd1};
    v_b  = '{32'd33, 32'd1, 32'd1, 32'd5, 32'd4, 32'd31,
             32'h0000_0FF0, 32'h0000_0FF0, 32'd3, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    v_r  = '{32'hC000_0000, 32'd1, 32'd0, 32'd0, 32'd16, 32'd1,
             32'h0000_FF00, 32'h0000_00F0, 32'd0, 32'd1, 32'd0, 32'd1};

    resetIn = 1'b1; readyIn = 1'b1; flushIn = 1'b0; robHead = 4'd0;
    addFlag = 1'b0; addOp = 4'd0; addVj = 32'd0; addVk = 32'd0; addQj = 4'd0; addQk = 4'd0;
    addQjBusy = 1'b0; addQkBusy = 1'b0; addDest = 4'd0;
    fwdFlag = 2'b00; fwdVal = 64'd0; fwdDest = 8'd0;
    tick(); tick();
    resetIn = 1'b0;
    @(negedge clk);
    chk("reset_outFlag", 32'(outFlag), 32'd0);
    chk("reset_count", 32'(count), 32'd0);
    chk("reset_full", 32'(full), 32'd0);

    // Single ADD, exactly one cycle after the select cycle.
    expect_res(32'd12, 4'd3);
    dispatch(4'd0, 32'd5, 4'd0, 1'b0, 32'd7, 4'd0, 1'b0, 4'd3);
    @(negedge clk);
    chk("single_count_after_add", 32'(count), 32'd1);
    tick();
    @(negedge clk);
    chk("single_latency_flag", 32'(outFlag), 32'd1);
    tick();
    @(negedge clk);
    chk("single_flag_drops", 32'(outFlag), 32'd0);
    chk("single_count_empty", 32'(count), 32'd0);

    // SUB waits on tag 3, woken by the station's own ADD result.
    expect_res(32'd10, 4'd3);
    expect_res(32'd8, 4'd4);
    dispatch(4'd1, 32'd0, 4'd3, 1'b1, 32'd2, 4'd0, 1'b0, 4'd4);
    dispatch(4'd0, 32'd10, 4'd0, 1'b0, 32'd0, 4'd0, 1'b0, 4'd3);
    drain(20);

    // Add-time snoop from fwd channel 1.
    fwdFlag = 2'b10; fwdDest = {4'd6, 4'd0}; fwdVal = {32'h55, 32'h0};
    expect_res(32'hF5, 4'd7);
    dispatch(4'd6, 32'd0, 4'd6, 1'b1, 32'hA0, 4'd0, 1'b0, 4'd7);
    fwdFlag = 2'b00;
    tick();
    @(negedge clk);
    chk("snoop_no_wait", 32'(outFlag), 32'd1);
    drain(10);

    // Oldest-first with robHead=14: dest 15 before dest 1.
    robHead = 4'd14;
    dispatch(4'd0, 32'd0, 4'd9, 1'b1, 32'd1, 4'd0, 1'b0, 4'd1);
    dispatch(4'd0, 32'd0, 4'd9, 1'b1, 32'd15, 4'd0, 1'b0, 4'd15);
    expect_res(32'd115, 4'd15);
    expect_res(32'd101, 4'd1);
    fwdFlag = 2'b01; fwdDest = {4'd0, 4'd9}; fwdVal = {32'd0, 32'd100};
    tick();
    fwdFlag = 2'b00;
    drain(20);

    // robHead=0: dest 1 first; channel 0 wins over channel 1 on the same tag.
    robHead = 4'd0;
    dispatch(4'd0, 32'd0, 4'd9, 1'b1, 32'd1, 4'd0, 1'b0, 4'd1);
    dispatch(4'd0, 32'd0, 4'd9, 1'b1, 32'd15, 4'd0, 1'b0, 4'd15);
    expect_res(32'd101, 4'd1);
    expect_res(32'd115, 4'd15);
    fwdFlag = 2'b11; fwdDest = {4'd9, 4'd9}; fwdVal = {32'd200, 32'd100};
    tick();
    fwdFlag = 2'b00;
    drain(20);

    // Fill, drop, flush.
    for (int i = 0; i < 16; i++) dispatch(4'd0, 32'd0, 4'd12, 1'b1, 32'd0, 4'd0, 1'b0, 4'(i));
    @(negedge clk);
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_count", 32'(count), 32'd16);
    dispatch(4'd0, 32'd1, 4'd0, 1'b0, 32'd1, 4'd0, 1'b0, 4'd2);
    @(negedge clk);
    chk("drop_count", 32'(count), 32'd16);
`ifdef RS_STAT_EN
    chk("stat_drop", statDrop, 32'd1);
`endif
    flushIn = 1'b1;
    tick();
    flushIn = 1'b0;
    @(negedge clk);
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_full", 32'(full), 32'd0);
    fwdFlag = 2'b01; fwdDest = {4'd0, 4'd12}; fwdVal = {32'd0, 32'd9};
    tick();
    fwdFlag = 2'b00;
    for (int n = 0; n < 3; n++) begin
      tick();
      @(negedge clk);
      chk("flush_no_out", 32'(outFlag), 32'd0);
    end

    // ALU edge values, one op per cycle.
    for (int i = 0; i < 12; i++) begin
      expect_res(v_r[i], 4'(i));
      dispatch(v_op[i], v_a[i], 4'd0, 1'b0, v_b[i], 4'd0, 1'b0, 4'(i));
    end
    drain(30);

    // readyIn low freezes outputs, and a dispatch attempt is ignored.
    expect_res(32'd5, 4'd5);
    dispatch(4'd0, 32'd2, 4'd0, 1'b0, 32'd3, 4'd0, 1'b0, 4'd5);
    tick();
    @(negedge clk);
    readyIn = 1'b0;
    addFlag = 1'b1; addOp = 4'd0; addVj = 32'd1; addVk = 32'd1; addDest = 4'd6;
    addQjBusy = 1'b0; addQkBusy = 1'b0;
    for (int n = 0; n < 3; n++) begin
      tick();
      @(negedge clk);
      chk("hold_flag", 32'(outFlag), 32'd1);
      chk("hold_val", outVal, 32'd5);
      chk("hold_dest", 32'(outDest), 32'd5);
      chk("hold_count", 32'(count), 32'd0);
    end
    addFlag = 1'b0;
    readyIn = 1'b1;
    tick();
    @(negedge clk);
    chk("resume_flag", 32'(outFlag), 32'd0);
    drain(5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reservation_station_gen.md
Name: reservation_station_gen

Overview:
Parametrised successor of the integer reservation station and ALU. It holds up to RS_DEPTH waiting ops and wakes operands from NUM_FWD external broadcast channels plus its own result. Each cycle it issues the oldest ready entry in ROB order to a built-in ALU and broadcasts the result one cycle later. It sits between the instruction unit (dispatch) and the CDB, alongside the LSB, and adds flush, add-time snoop and oldest-first selection.

Parameters:
- ROB_WIDTH, 4, ROB tag width; ROB_SIZE = 2**ROB_WIDTH.
- RS_DEPTH, 16, number of entries; any value from 2 to 32, power of two not required.
- NUM_FWD, 2, number of external forward channels (LSB, load unit, ...).
- DATA_WIDTH, 32, operand and result width; must be a power of two, at least 8.

Ports:
- clockIn in 1: clock, rising edge.
- resetIn in 1: asynchronous, active-high reset.
- readyIn in 1: global enable; low freezes the block.
- flushIn in 1: misprediction flush.
- robHead in ROB_WIDTH: tag of the oldest in-flight ROB entry.
- addFlag in 1: dispatch valid.
- addOp in 4: op code.
- addVj in DATA_WIDTH: operand j value.
- addQj in ROB_WIDTH: operand j tag.
- addQjBusy in 1: operand j still pending.
- addVk in DATA_WIDTH: operand k value.
- addQk in ROB_WIDTH: operand k tag.
- addQkBusy in 1: operand k still pending.
- addDest in ROB_WIDTH: destination ROB tag.
- full out 1: all entries busy.
- count out clog2(RS_DEPTH+1): number of busy entries.
- fwdFlag in NUM_FWD: per-channel valid.
- fwdVal in NUM_FWD*DATA_WIDTH: flattened values; channel c occupies bits [c*DATA_WIDTH +: DATA_WIDTH].
- fwdDest in NUM_FWD*ROB_WIDTH: flattened tags, same packing.
- outFlag out 1: result valid.
- outVal out DATA_WIDTH: result.
- outDest out ROB_WIDTH: result tag.

Behaviour:
- Reset: busy, QjBusy, QkBusy, outFlag, outVal, outDest and stat counters all go to 0. full=0, count=0.
- full and count derive only from registered busy state.
- Dispatch: if addFlag && readyIn && !flushIn && !full, load the lowest-index free entry. addFlag while full is dropped silently; the dispatcher must check full.
- Add-time snoop: if addQjBusy and addQj equals any valid fwdDest or {outFlag,outDest} in the same cycle, the entry is stored with Vj = that value and QjBusy = 0. Vk follows the same rule.
- Wakeup: every busy entry with a pending operand whose tag matches a valid channel captures the value that cycle. Channel priority: own result, then fwd channel 0, then 1, and so on.
- Ready means busy && !QjBusy && !QkBusy, evaluated on registered state. An entry woken this cycle issues no earlier than the next cycle.
- Select: among ready entries, pick the minimum age, where age = (dest - robHead) mod ROB_SIZE. Ties go to the lowest index.
- Issue: the selected entry is freed at the edge. outFlag, outVal and outDest are registered, so latency is exactly 1 cycle from the selecting edge. outFlag=0 when nothing is ready.
- Same-cycle dispatch and issue: issue frees one entry while dispatch fills another. Dispatch cannot reuse the slot being freed in that cycle.
- ALU ops:
  - ADD 0, SUB 1, SLL 2, XOR 3, SRL 4, SRA 5, OR 6, AND 7, EQ 8, NE 9, LT 10, GE 11, LTU 12, GEU 13.
  - Shift amount is rs2[clog2(DATA_WIDTH)-1:0]. SRA is signed.
  - Compare ops return 1 or 0, zero-extended.
  - Ops 14 and 15 return 0.
- readyIn low: all state, counters and outputs hold.
- flushIn high: at the edge, clears all busy bits and outFlag. It overrides dispatch, issue and readyIn.
- Reset asserted mid-operation: all of the above clears immediately (asynchronous).

Optional Feature:
- Macro: RS_STAT_EN.
- When defined, adds three outputs:
  - statIssue, 32 bits: increments per issued op.
  - statFull, 32 bits: increments per readyIn cycle with full=1.
  - statDrop, 32 bits: increments per dropped addFlag.
- The counters wrap, clear on reset, and are not cleared by flushIn.
- When not defined, these ports and their logic are absent.

Decomposition:
- Package rs_pkg holds the op-code localparams (ADD..GEU), the op width of 4, and an age-compare function.
- One sub-module, rs_alu: purely combinational; op, a, b in; result out; parametrised by DATA_WIDTH.
- Entry storage, wakeup, select and dispatch logic stay in the top module.

Test Plan:
- Reset then single dispatch: dispatch ADD Vj=5, Vk=7, both ready, dest=3. The cycle after the dispatch edge is the select cycle; next edge gives outFlag=1, outVal=12, outDest=3. Then outFlag=0 and count=0.
- Wakeup and self-forward: dispatch SUB with Qj=3 busy, Vk=2, dest=4, plus ADD ready 10+0, dest=3. ADD issues first and broadcasts 10. SUB wakes, then outputs 8 with dest=4.
- Add-time snoop: fwd channel 1 broadcasts tag 6, value 0x55, in the same cycle as dispatch of OR with Qj=6 busy, Vk=0xA0. The entry never waits and the output is 0xF5.
- Oldest-first: robHead=14. Ready entries have dest 1 (index 0) and dest 15 (index 1). dest 15 issues first, then dest 1. With robHead=0, dest 1 issues first.
- Full, drop and flush: fill RS_DEPTH entries with pending operands, so full=1 and count=RS_DEPTH. An extra addFlag is ignored (statDrop=1 if RS_STAT_EN). flushIn gives count=0 and no outFlag on the following cycles.
- Edge ALU values: SRA 0x80000000 by 33 gives 0xC0000000. LT -1 vs 1 gives 1. LTU -1 vs 1 gives 0. op 15 gives 0. With readyIn low for 3 cycles, outputs hold.
